// File: rtl/double_divider.sv
// IEEE-754 double-precision divider, z = a / b, round-to-nearest-even with denormal support.
// Iterative restoring datapath producing one quotient bit per clock behind stb/ack handshakes.
module double_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [63:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [63:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    typedef enum logic [3:0] {
        GET_A,
        GET_B,
        UNPACK,
        SPECIAL_CASES,
        NORMALISE_A,
        NORMALISE_B,
        DIVIDE_0,
        DIVIDE_1,
        DIVIDE_2,
        NORMALISE_1,
        NORMALISE_2,
        ROUND,
        PACK,
        PUT_Z
    } state_t;

    localparam logic signed [12:0] EXP_SPECIAL = 13'sd1024;
    localparam logic signed [12:0] EXP_ZERO    = -13'sd1023;
    localparam logic signed [12:0] EXP_DENORM  = -13'sd1022;
    localparam logic signed [12:0] EXP_MAX     = 13'sd1023;
    localparam logic [63:0]        QNAN        = 64'hFFF8_0000_0000_0000;

    state_t             state;
    logic [63:0]        a;
    logic [63:0]        b;
    logic [63:0]        z;
    logic [52:0]        a_m;
    logic [52:0]        b_m;
    logic [52:0]        z_m;
    logic signed [12:0] a_e;
    logic signed [12:0] b_e;
    logic signed [12:0] z_e;
    logic               a_s;
    logic               b_s;
    logic               z_s;
    logic               guard;
    logic               round_bit;
    logic               sticky;
    logic [56:0]        quotient;
    logic [53:0]        remainder;
    logic [5:0]         count;

    logic               a_nan;
    logic               b_nan;
    logic               a_inf;
    logic               b_inf;
    logic               a_zero;
    logic               b_zero;
    logic               sign_xor;
    logic               rem_ge;
    logic [52:0]        rem_diff;

    // Operand classification, valid while sitting in SPECIAL_CASES after unpack.
    assign a_nan    = (a_e == EXP_SPECIAL) && (a_m != '0);
    assign b_nan    = (b_e == EXP_SPECIAL) && (b_m != '0);
    assign a_inf    = (a_e == EXP_SPECIAL) && (a_m == '0);
    assign b_inf    = (b_e == EXP_SPECIAL) && (b_m == '0);
    assign a_zero   = (a_e == EXP_ZERO) && (a_m == '0);
    assign b_zero   = (b_e == EXP_ZERO) && (b_m == '0);
    assign sign_xor = a_s ^ b_s;

    // The remainder always stays below 2*b_m, so the difference fits in 53 bits.
    assign rem_ge   = remainder >= {1'b0, b_m};
    assign rem_diff = remainder[52:0] - b_m;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= GET_A;
            input_a_ack  <= 1'b0;
            input_b_ack  <= 1'b0;
            output_z_stb <= 1'b0;
            output_z     <= '0;
            a            <= '0;
            b            <= '0;
            z            <= '0;
            a_m          <= '0;
            b_m          <= '0;
            z_m          <= '0;
            a_e          <= '0;
            b_e          <= '0;
            z_e          <= '0;
            a_s          <= 1'b0;
            b_s          <= 1'b0;
            z_s          <= 1'b0;
            guard        <= 1'b0;
            round_bit    <= 1'b0;
            sticky       <= 1'b0;
            quotient     <= '0;
            remainder    <= '0;
            count        <= '0;
        end else begin
            case (state)
                GET_A: begin
                    input_a_ack <= 1'b1;
                    if (input_a_ack && input_a_stb) begin
                        a           <= input_a;
                        input_a_ack <= 1'b0;
                        state       <= GET_B;
                    end
                end

                GET_B: begin
                    input_b_ack <= 1'b1;
                    if (input_b_ack && input_b_stb) begin
                        b           <= input_b;
                        input_b_ack <= 1'b0;
                        state       <= UNPACK;
                    end
                end

                UNPACK: begin
                    a_m   <= {1'b0, a[51:0]};
                    b_m   <= {1'b0, b[51:0]};
                    a_e   <= $signed({2'b00, a[62:52]}) - 13'sd1023;
                    b_e   <= $signed({2'b00, b[62:52]}) - 13'sd1023;
                    a_s   <= a[63];
                    b_s   <= b[63];
                    state <= SPECIAL_CASES;
                end

                SPECIAL_CASES: begin
                    state <= PUT_Z;
                    if (a_nan || b_nan) begin
                        z <= QNAN;
                    end else if (a_inf && b_inf) begin
                        z <= QNAN;
                    end else if (a_inf) begin
                        z <= {sign_xor, 11'h7FF, 52'd0};
                    end else if (b_inf) begin
                        z <= {sign_xor, 63'd0};
                    end else if (b_zero) begin
                        z <= a_zero ? QNAN : {sign_xor, 11'h7FF, 52'd0};
                    end else if (a_zero) begin
                        z <= {sign_xor, 63'd0};
                    end else begin
                        // Denormals keep the minimum exponent; normals gain the hidden bit.
                        if (a_e == EXP_ZERO) begin
                            a_e <= EXP_DENORM;
                        end else begin
                            a_m[52] <= 1'b1;
                        end
                        if (b_e == EXP_ZERO) begin
                            b_e <= EXP_DENORM;
                        end else begin
                            b_m[52] <= 1'b1;
                        end
                        state <= NORMALISE_A;
                    end
                end

                NORMALISE_A: begin
                    if (a_m[52]) begin
                        state <= NORMALISE_B;
                    end else begin
                        a_m <= a_m << 1;
                        a_e <= a_e - 13'sd1;
                    end
                end

                NORMALISE_B: begin
                    if (b_m[52]) begin
                        state <= DIVIDE_0;
                    end else begin
                        b_m <= b_m << 1;
                        b_e <= b_e - 13'sd1;
                    end
                end

                DIVIDE_0: begin
                    z_s       <= sign_xor;
                    z_e       <= a_e - b_e;
                    remainder <= {1'b0, a_m};
                    quotient  <= '0;
                    count     <= '0;
                    state     <= DIVIDE_1;
                end

                DIVIDE_1: begin
                    if (rem_ge) begin
                        quotient  <= {quotient[55:0], 1'b1};
                        remainder <= {rem_diff, 1'b0};
                    end else begin
                        quotient  <= {quotient[55:0], 1'b0};
                        remainder <= {remainder[52:0], 1'b0};
                    end
                    count <= count + 6'd1;
                    if (count == 6'd56) begin
                        state <= DIVIDE_2;
                    end
                end

                DIVIDE_2: begin
                    z_m       <= quotient[56:4];
                    guard     <= quotient[3];
                    round_bit <= quotient[2];
                    sticky    <= quotient[1] | quotient[0] | (remainder != '0);
                    state     <= NORMALISE_1;
                end

                NORMALISE_1: begin
                    // Quotient lies in (0.5, 2), so at most one left shift happens here.
                    if (!z_m[52]) begin
                        z_m       <= {z_m[51:0], guard};
                        guard     <= round_bit;
                        round_bit <= 1'b0;
                        z_e       <= z_e - 13'sd1;
                    end else begin
                        state <= NORMALISE_2;
                    end
                end

                NORMALISE_2: begin
                    if (z_e < EXP_DENORM) begin
                        z_m       <= z_m >> 1;
                        guard     <= z_m[0];
                        round_bit <= guard;
                        sticky    <= sticky | round_bit;
                        z_e       <= z_e + 13'sd1;
                    end else begin
                        state <= ROUND;
                    end
                end

                ROUND: begin
                    if (guard && (round_bit || sticky || z_m[0])) begin
                        z_m <= z_m + 53'd1;
                        if (z_m == '1) begin
                            z_e <= z_e + 13'sd1;
                        end
                    end
                    state <= PACK;
                end

                PACK: begin
                    if (z_e > EXP_MAX) begin
                        z <= {z_s, 11'h7FF, 52'd0};
                    end else if ((z_e == EXP_DENORM) && !z_m[52]) begin
                        z <= {z_s, 11'd0, z_m[51:0]};
                    end else begin
                        z <= {z_s, z_e[10:0] + 11'd1023, z_m[51:0]};
                    end
                    state <= PUT_Z;
                end

                PUT_Z: begin
                    output_z_stb <= 1'b1;
                    output_z     <= z;
                    if (output_z_stb && output_z_ack) begin
                        output_z_stb <= 1'b0;
                        state        <= GET_A;
                    end
                end

                default: begin
                    state <= GET_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_double_divider.sv
// Directed self-checking bench for double_divider: results, latencies, specials and handshakes.
module tb_double_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] input_a = '0;
    logic        input_a_stb = 1'b0;
    logic        input_a_ack;
    logic [63:0] input_b = '0;
    logic        input_b_stb = 1'b0;
    logic        input_b_ack;
    logic [63:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack = 1'b0;

    int checks = 0;
    int failures = 0;

    double_divider dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .input_b      (input_b),
        .input_b_stb  (input_b_stb),
        .input_b_ack  (input_b_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    always #5 clk = ~clk;

    // Returns right after the rising edge that accepts b.
    task automatic send_operands(input logic [63:0] a, input logic [63:0] b, output bit ok);
        int n;
        ok = 1'b1;
        @(negedge clk);
        input_a = a;
        input_a_stb = 1'b1;
        n = 0;
        while (input_a_ack !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (input_a_ack !== 1'b1) ok = 1'b0;
        else @(posedge clk);
        @(negedge clk);
        input_a_stb = 1'b0;
        input_b = b;
        input_b_stb = 1'b1;
        n = 0;
        while (ok && input_b_ack !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (input_b_ack !== 1'b1) begin
            ok = 1'b0;
            input_b_stb = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic wait_result(output logic [63:0] z, output int lat);
        lat = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            input_b_stb = 1'b0;
            if (output_z_stb === 1'b1) break;
        end
        if (output_z_stb !== 1'b1) begin
            checks++;
            failures++;
            $display("[TB] FAIL result_timeout: stb=%b after %0d edges, required 1", output_z_stb, lat);
            lat = -1;
        end
        z = output_z;
    endtask

    task automatic consume();
        output_z_ack = 1'b1;
        @(negedge clk);
        output_z_ack = 1'b0;
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, output logic [63:0] z, output int lat);
        bit ok;
        send_operands(a, b, ok);
        if (!ok) begin
            checks++;
            failures++;
            $display("[TB] FAIL operand_handshake: ack never seen for a=%h b=%h, required ack=1", a, b);
            z = '0;
            lat = -1;
        end else begin
            wait_result(z, lat);
            consume();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        checks++;
        if ({input_a_ack, input_b_ack, output_z_stb} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_handshake: got a_ack/b_ack/stb=%b required 000", {input_a_ack, input_b_ack, output_z_stb});
        end
        checks++;
        if (output_z !== 64'd0) begin
            failures++;
            $display("[TB] FAIL reset_z: got %h required 0", output_z);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({input_a_ack, input_b_ack} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL first_ack: got a_ack/b_ack=%b required 10", {input_a_ack, input_b_ack});
        end
    endtask

    task automatic test_divide();
        logic [63:0] z;
        int lat;
        run_op(64'h4018000000000000, 64'h4000000000000000, z, lat);
        checks++;
        if (z !== 64'h4008000000000000) begin
            failures++;
            $display("[TB] FAIL div_6_2: got %h required 4008000000000000", z);
        end
        checks++;
        if (lat != 68) begin
            failures++;
            $display("[TB] FAIL div_6_2_latency: got %0d required 68", lat);
        end
    endtask

    task automatic test_rounding();
        logic [63:0] ra [3] = '{64'h3FF0000000000000, 64'h4000000000000000, 64'h3FF0000000000000};
        logic [63:0] rb [3] = '{64'h4008000000000000, 64'h4008000000000000, 64'h4024000000000000};
        logic [63:0] rz [3] = '{64'h3FD5555555555555, 64'h3FE5555555555555, 64'h3FB999999999999A};
        logic [63:0] z;
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(ra[i], rb[i], z, lat);
            checks++;
            if (z !== rz[i]) begin
                failures++;
                $display("[TB] FAIL rounding_%0d: got %h required %h", i, z, rz[i]);
            end
            checks++;
            if (lat != 69) begin
                failures++;
                $display("[TB] FAIL rounding_%0d_latency: got %0d required 69", i, lat);
            end
        end
    endtask

    task automatic test_specials();
        logic [63:0] sa [7] = '{64'h3FF0000000000000, 64'h0000000000000000, 64'hBFF0000000000000,
                                64'h7FF8000000000001, 64'h7FF0000000000000, 64'hFFF0000000000000,
                                64'h8000000000000000};
        logic [63:0] sb [7] = '{64'h0000000000000000, 64'h0000000000000000, 64'h7FF0000000000000,
                                64'h3FF0000000000000, 64'h7FF0000000000000, 64'h4000000000000000,
                                64'h4000000000000000};
        logic [63:0] sz [7] = '{64'h7FF0000000000000, 64'hFFF8000000000000, 64'h8000000000000000,
                                64'hFFF8000000000000, 64'hFFF8000000000000, 64'hFFF0000000000000,
                                64'h8000000000000000};
        logic [63:0] z;
        int lat;
        for (int i = 0; i < 7; i++) begin
            run_op(sa[i], sb[i], z, lat);
            checks++;
            if (z !== sz[i]) begin
                failures++;
                $display("[TB] FAIL special_%0d: got %h required %h", i, z, sz[i]);
            end
            checks++;
            if (lat != 3) begin
                failures++;
                $display("[TB] FAIL special_%0d_latency: got %0d required 3", i, lat);
            end
        end
    endtask

    task automatic test_denormals();
        logic [63:0] z;
        int lat;
        run_op(64'h0000000000000002, 64'h4000000000000000, z, lat);
        checks++;
        if (z !== 64'h0000000000000001) begin
            failures++;
            $display("[TB] FAIL denorm_2_div_2: got %h required 0000000000000001", z);
        end
        checks++;
        if (lat != 171) begin
            failures++;
            $display("[TB] FAIL denorm_2_div_2_latency: got %0d required 171", lat);
        end
        run_op(64'h0000000000000001, 64'h4000000000000000, z, lat);
        checks++;
        if (z !== 64'h0000000000000000) begin
            failures++;
            $display("[TB] FAIL denorm_tie_even: got %h required 0000000000000000", z);
        end
        checks++;
        if (lat != 173) begin
            failures++;
            $display("[TB] FAIL denorm_tie_even_latency: got %0d required 173", lat);
        end
    endtask

    task automatic test_overflow();
        logic [63:0] z;
        int lat;
        run_op(64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, z, lat);
        checks++;
        if (z !== 64'h7FF0000000000000) begin
            failures++;
            $display("[TB] FAIL overflow: got %h required 7FF0000000000000", z);
        end
        checks++;
        if (lat != 68) begin
            failures++;
            $display("[TB] FAIL overflow_latency: got %0d required 68", lat);
        end
    endtask

    task automatic test_hold();
        logic [63:0] z;
        int lat;
        bit ok;
        send_operands(64'hBFF0000000000000, 64'h7FF0000000000000, ok);
        if (!ok) begin
            checks++;
            failures++;
            $display("[TB] FAIL hold_handshake: operand ack missing, required ack=1");
        end else begin
            wait_result(z, lat);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                checks++;
                if (output_z_stb !== 1'b1 || output_z !== 64'h8000000000000000) begin
                    failures++;
                    $display("[TB] FAIL hold_stable_%0d: got stb=%b z=%h required stb=1 z=8000000000000000", i, output_z_stb, output_z);
                end
            end
            consume();
            checks++;
            if (output_z_stb !== 1'b0) begin
                failures++;
                $display("[TB] FAIL hold_drop: got stb=%b required 0", output_z_stb);
            end
            repeat (5) @(negedge clk);
            checks++;
            if (output_z_stb !== 1'b0 || output_z !== 64'h8000000000000000) begin
                failures++;
                $display("[TB] FAIL hold_no_reassert: got stb=%b z=%h required stb=0 z=8000000000000000", output_z_stb, output_z);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] z;
        int lat;
        bit ok;
        send_operands(64'h4018000000000000, 64'h4000000000000000, ok);
        repeat (20) @(posedge clk);
        @(negedge clk);
        input_b_stb = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if ({input_a_ack, input_b_ack, output_z_stb} !== 3'b000 || output_z !== 64'd0) begin
            failures++;
            $display("[TB] FAIL mid_reset: got acks/stb=%b z=%h required 000 z=0", {input_a_ack, input_b_ack, output_z_stb}, output_z);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (output_z_stb !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_reset_hold: got stb=%b required 0", output_z_stb);
        end
        rst = 1'b1;
        run_op(64'h3FF0000000000000, 64'h4008000000000000, z, lat);
        checks++;
        if (z !== 64'h3FD5555555555555 || lat != 69) begin
            failures++;
            $display("[TB] FAIL after_reset: got %h lat %0d required 3FD5555555555555 lat 69", z, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] z;
        int lat;
        bit ok;
        output_z_ack = 1'b1;
        send_operands(64'h4018000000000000, 64'h4000000000000000, ok);
        if (ok) wait_result(z, lat);
        else z = '0;
        checks++;
        if (z !== 64'h4008000000000000) begin
            failures++;
            $display("[TB] FAIL b2b_first: got %h required 4008000000000000", z);
        end
        @(negedge clk);
        checks++;
        if (output_z_stb !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_stb_drop: got stb=%b required 0", output_z_stb);
        end
        send_operands(64'h3FF0000000000000, 64'h4024000000000000, ok);
        if (ok) wait_result(z, lat);
        else z = '0;
        checks++;
        if (z !== 64'h3FB999999999999A) begin
            failures++;
            $display("[TB] FAIL b2b_second: got %h required 3FB999999999999A", z);
        end
        output_z_ack = 1'b0;
    endtask

    initial begin
        $display("[TB] double_divider directed test start");
        test_reset();
        test_divide();
        test_rounding();
        test_specials();
        test_denormals();
        test_overflow();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "[TB] global timeout");
    end

endmodule
